// File: rtl/kbuf_pkg.sv
// Kernel-buffer load geometry and FSM encoding, shared by
// the stream loader and the buffer wrapper.
package kbuf_pkg;

    localparam int DATALEN   = 64;
    localparam int NKERNBEAT = 512;
    localparam int NSELBEAT  = 128;
    localparam int SELLEN    = 5;
    localparam int NSELPB    = 8;
    localparam int SELW      = SELLEN * NSELPB;
    localparam int KCNTW     = $clog2(NKERNBEAT);
    localparam int SCNTW     = $clog2(NSELBEAT);

    typedef enum logic [1:0] {
        IDLE,
        KERN,
        SEL,
        DONE
    } kstate_e;

    function automatic logic [DATALEN-1:0] sel_pack(
        input logic [DATALEN-1:0] d
    );
        logic [DATALEN-1:0] r;
        r = '0;
        r[SELW-1:0] = d[SELW-1:0];
        return r;
    endfunction

endpackage

// File: rtl/buf_kernel_loader.sv
// Streams one kernel-buffer load (kernel beats then select beats)
// from a valid/ready source into the buffer write port.
module buf_kernel_loader
    import kbuf_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               buf_busy,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATALEN-1:0] s_data,
    output logic               invalid,
    output logic               iskern,
    output logic               issel,
    output logic [DATALEN-1:0] indata,
    output logic               busy,
    output logic               done
);

    localparam logic [KCNTW-1:0] KLAST = KCNTW'(NKERNBEAT - 1);
    localparam logic [SCNTW-1:0] SLAST = SCNTW'(NSELBEAT - 1);

    kstate_e            state_q, state_d;
    logic [KCNTW-1:0]   kcnt_q, kcnt_d;
    logic [SCNTW-1:0]   scnt_q, scnt_d;
    logic               vld_q, vld_d;
    logic               kern_q, kern_d;
    logic               sel_q, sel_d;
    logic [DATALEN-1:0] data_q, data_d;
    logic               acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            kcnt_q  <= '0;
            scnt_q  <= '0;
            vld_q   <= 1'b0;
            kern_q  <= 1'b0;
            sel_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            kcnt_q  <= kcnt_d;
            scnt_q  <= scnt_d;
            vld_q   <= vld_d;
            kern_q  <= kern_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kcnt_d  = kcnt_q;
        scnt_d  = scnt_q;
        s_ready = ((state_q == KERN) || (state_q == SEL)) && !buf_busy;
        acc     = s_valid && s_ready;
        vld_d   = acc;
        kern_d  = acc && (state_q == KERN);
        sel_d   = acc && (state_q == SEL);
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = KERN;
            end
            KERN: begin
                if (acc) begin
                    data_d = s_data;
                    if (kcnt_q == KLAST) begin
                        kcnt_d  = '0;
                        state_d = SEL;
                    end else begin
                        kcnt_d = kcnt_q + 1'b1;
                    end
                end
            end
            SEL: begin
                if (acc) begin
                    data_d = sel_pack(s_data);
                    if (scnt_q == SLAST) begin
                        scnt_d  = '0;
                        state_d = DONE;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write strobes are single-cycle: vld_q is recomputed every edge.
    assign invalid = vld_q;
    assign iskern  = kern_q;
    assign issel   = sel_q;
    assign indata  = data_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_buf_kernel_loader.sv
// Randomized bench for buf_kernel_loader with a load-level reference model.
module tb_buf_kernel_loader;

    localparam int NK   = 512;
    localparam int NS   = 128;
    localparam int NT   = NK + NS;
    localparam int MAXC = 6000;
    localparam logic [63:0] SMASK = 64'h0000_00FF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        buf_busy;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        invalid;
    logic        iskern;
    logic        issel;
    logic [63:0] indata;
    logic        busy;
    logic        done;

    buf_kernel_loader dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .buf_busy (buf_busy),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .invalid  (invalid),
        .iskern   (iskern),
        .issel    (issel),
        .indata   (indata),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int gcyc   = 0;
    int mode   = 0;
    logic [63:0] rnd [NT];

    int wr_cnt, kern_cnt, sel_cnt, done_cnt;
    int done_cyc, k511_cyc, s0_cyc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, gcyc);
        end
    endtask

    function automatic logic [63:0] beat_data(input int i);
        logic [31:0] lo, hi;
        lo = 32'(i);
        hi = 32'(i + 1);
        if (mode == 0) return {hi, lo};
        if (i == NK + 8) return 64'hFFFF_FFFF_FFFF_FFFF;
        return rnd[i];
    endfunction

    // Reference model: a load is a run of NT accepted beats; the first
    // NK are kernel writes, the rest select writes with upper bits cleared.
    int          m_phase;
    int          m_n;
    logic        e_inv, e_k, e_s;
    logic [63:0] e_data;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase = 0;
            m_n     = 0;
            e_inv   = 0;
            e_k     = 0;
            e_s     = 0;
            e_data  = '0;
        end else begin
            e_inv = 0;
            e_k   = 0;
            e_s   = 0;
            if (m_phase == 0) begin
                if (start) begin
                    m_phase = 1;
                    m_n     = 0;
                end
            end else if (m_phase == 1) begin
                if (s_valid && !buf_busy) begin
                    e_inv  = 1;
                    e_k    = (m_n < NK);
                    e_s    = (m_n >= NK);
                    e_data = (m_n < NK) ? s_data : (s_data & SMASK);
                    m_n++;
                    if (m_n == NT) m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(posedge clk) gcyc++;

    always @(negedge clk) begin
        if (rstn) begin
            chk("s_ready", 64'(s_ready), 64'(m_phase == 1 && !buf_busy));
            chk("invalid", 64'(invalid), 64'(e_inv));
            chk("iskern", 64'(iskern), 64'(e_k));
            chk("issel", 64'(issel), 64'(e_s));
            chk("indata", indata, e_data);
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("done", 64'(done), 64'(m_phase == 2));
            if (invalid) begin
                if (mode == 1 && wr_cnt == NK + 8) begin
                    chk("sel_allF", indata, 64'h0000_00FF_FFFF_FFFF);
                    chk("sel_allF_issel", 64'(issel), 64'd1);
                end
                if (iskern && kern_cnt == NK - 1) k511_cyc = gcyc;
                if (issel && sel_cnt == 0) s0_cyc = gcyc;
                if (mode == 0 && iskern && kern_cnt == NK - 1)
                    chk("kern511", indata, 64'h0000_0200_0000_01FF);
                if (mode == 0 && issel && sel_cnt == 0)
                    chk("sel0", indata, 64'h0000_0001_0000_0200);
                wr_cnt++;
                if (iskern) kern_cnt++;
                if (issel) sel_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = gcyc;
            end
        end
    end

    task automatic run_load(input int vprob, input int busy_at,
                            input int abort_at, input int restart_at,
                            output int st_cyc);
        int   acc;
        int   cyc;
        int   busy_left;
        logic rdy;
        acc       = 0;
        cyc       = 0;
        busy_left = 0;
        wr_cnt    = 0;
        kern_cnt  = 0;
        sel_cnt   = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        k511_cyc  = -1;
        s0_cyc    = -1;
        s_valid   = 0;
        start     = 1;
        @(posedge clk);
        #1;
        st_cyc = gcyc;
        start  = 0;
        while (acc < NT && cyc < MAXC) begin
            if (!s_valid && $urandom_range(99) < vprob) begin
                s_valid = 1;
                s_data  = beat_data(acc);
            end
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == restart_at);
            if (s_valid && rdy) begin
                acc++;
                s_valid = 0;
                if (acc == busy_at) busy_left = 20;
                if (acc == abort_at) begin
                    #2;
                    rstn = 0;
                    #1;
                    chk("abort_busy", 64'(busy), 64'd0);
                    chk("abort_inv", 64'(invalid), 64'd0);
                    chk("abort_done", 64'(done), 64'd0);
                    @(posedge clk);
                    #1;
                    rstn = 1;
                    return;
                end
            end
            buf_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
        start    = 0;
        s_valid  = 0;
        buf_busy = 0;
        if (acc < NT) chk("beat_budget", 64'(acc), 64'(NT));
    endtask

    task automatic finish_load(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        chk({tag, "_writes"}, 64'(wr_cnt), 64'(NT));
        chk({tag, "_kern"}, 64'(kern_cnt), 64'(NK));
        chk({tag, "_sel"}, 64'(sel_cnt), 64'(NS));
        chk({tag, "_donecnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    int st;

    initial begin
        rstn     = 0;
        start    = 0;
        buf_busy = 0;
        s_valid  = 0;
        s_data   = '0;
        for (int i = 0; i < NT; i++) rnd[i] = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_inv", 64'(invalid), 64'd0);
        chk("rst_kern", 64'(iskern), 64'd0);
        chk("rst_sel", 64'(issel), 64'd0);
        chk("rst_data", indata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rstn = 1;
        s_valid = 1;
        s_data  = 64'h1234;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ready", 64'(s_ready), 64'd0);
        s_valid = 0;

        mode = 0;
        run_load(100, -1, -1, -1, st);
        finish_load("t1");
        chk("t1_done_time", 64'(done_cyc - st), 64'd640);
        chk("t1_boundary", 64'(s0_cyc - k511_cyc), 64'd1);

        mode = 1;
        run_load(50, -1, -1, -1, st);
        finish_load("t3");

        mode = 0;
        run_load(100, 100, -1, -1, st);
        finish_load("t4");

        mode = 1;
        run_load(100, -1, NK + 40, -1, st);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_nodone", 64'(done_cnt), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);
        run_load(70, -1, -1, 50, st);
        finish_load("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
